graphics_draw_ctrl: RTL and testbench

//   Sequences the graphics datapath to draw one 8x8 square per command.

---
 rtl/graphics_draw_ctrl.sv | 110 +++++++++++
 tb/tb_graphics_draw_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/graphics_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : graphics_draw_ctrl
// Description : Round-robin draw controller that sequences the graphics
//               datapath to plot one 8x8 square per granted command.
// Revision    : 1.0 - initial release
// ============================================================================
module graphics_draw_ctrl #(
    parameter int PIXELS = 64,
    parameter int CNT_W  = 6
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req0,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [2:0] colour0,
    input  logic       flash0,
    input  logic       req1,
    input  logic [7:0] x1,
    input  logic [6:0] y1,
    input  logic [2:0] colour1,
    input  logic       flash1,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       dp_load,
    output logic       dp_enable,
    output logic       dp_flash,
    output logic [7:0] dp_x,
    output logic [7:0] dp_y,
    output logic [2:0] dp_colour,
    output logic       plot
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(PIXELS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic             r_last_grant;
    logic             r_grant;
    logic [7:0]       r_x;
    logic [6:0]       r_y;
    logic [2:0]       r_colour;
    logic             r_flash;
    logic             w_grant;

    // On a tie the requester that did not win last time is served.
    assign w_grant = (req0 & req1) ? ~r_last_grant : req1;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (req0 | req1) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_DRAW;
            ST_DRAW: if (r_count == LAST_PIXEL) w_next_state = ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
            r_flash      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_x          <= w_grant ? x1      : x0;
                        r_y          <= w_grant ? y1      : y0;
                        r_colour     <= w_grant ? colour1 : colour0;
                        r_flash      <= w_grant ? flash1  : flash0;
                    end
                end
                ST_LOAD: r_count <= '0;
                ST_DRAW: r_count <= r_count + 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Every output is decoded from state or the captured command only.
    assign busy      = (r_state != ST_IDLE);
    assign dp_load   = (r_state == ST_LOAD);
    assign dp_enable = (r_state == ST_LOAD) || (r_state == ST_DRAW);
    assign dp_flash  = (r_state == ST_LOAD) && r_flash;
    assign plot      = (r_state == ST_DRAW);
    assign done0     = (r_state == ST_DONE) && !r_grant;
    assign done1     = (r_state == ST_DONE) &&  r_grant;
    assign dp_x      = r_x;
    assign dp_y      = {1'b0, r_y};
    assign dp_colour = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_graphics_draw_ctrl.sv
`default_nettype none
// Testbench for graphics_draw_ctrl: table of directed commands plus
// hand-written reset, tie-break and mid-draw abort sequences.
module tb_graphics_draw_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req0, req1, flash0, flash1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] colour0, colour1;
    logic       done0, done1, busy, dp_load, dp_enable, dp_flash, plot;
    logic [7:0] dp_x, dp_y;
    logic [2:0] dp_colour;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       r0;
        logic [7:0] x0;
        logic [6:0] y0;
        logic [2:0] c0;
        logic       f0;
        logic       r1;
        logic [7:0] x1;
        logic [6:0] y1;
        logic [2:0] c1;
        logic       f1;
        logic       late1;
        logic       eg;
        logic [7:0] ex;
        logic [7:0] ey;
        logic [2:0] ec;
        logic       ef;
    } vec_t;

    graphics_draw_ctrl dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .x0(x0), .y0(y0), .colour0(colour0), .flash0(flash0),
        .req1(req1), .x1(x1), .y1(y1), .colour1(colour1), .flash1(flash1),
        .done0(done0), .done1(done1), .busy(busy),
        .dp_load(dp_load), .dp_enable(dp_enable), .dp_flash(dp_flash),
        .dp_x(dp_x), .dp_y(dp_y), .dp_colour(dp_colour), .plot(plot)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done0 && done1) begin
            bad++;
            $display("FAIL two_dones actual=%b%b required=not both", done1, done0);
        end
        if (plot && !(dp_enable && !dp_load)) begin
            bad++;
            $display("FAIL plot_outside_draw actual=1 required=0");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int  plots;
        int  done_k;
        int  flash_draw;
        logic fin;
        logic [1:0] dsel;
        chk("idle_before", busy, 0);
        req0 = v.r0; x0 = v.x0; y0 = v.y0; colour0 = v.c0; flash0 = v.f0;
        req1 = v.r1; x1 = v.x1; y1 = v.y1; colour1 = v.c1; flash1 = v.f1;
        if (v.late1) req1 = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("load_pulse", {dp_load, dp_enable, plot, busy}, 4'b1101);
        chk("load_flash", dp_flash, v.ef);
        chk("load_cmd", {dp_x, dp_y, dp_colour}, {v.ex, v.ey, v.ec});
        plots = 0; done_k = 0; flash_draw = 0; fin = 1'b0; dsel = 2'b00;
        for (int k = 2; k < 100 && !fin; k++) begin
            @(posedge clock); @(negedge clock);
            if (v.late1 && k == 12) req1 = 1'b1;
            if (plot) plots++;
            if (plot && dp_flash) flash_draw++;
            if (done0 || done1) begin
                fin = 1'b1;
                done_k = k;
                dsel = {done1, done0};
                chk("done_cmd_hold", {dp_x, dp_y, dp_colour, dp_enable, plot},
                    {v.ex, v.ey, v.ec, 2'b00});
            end
        end
        chk("done_latency", done_k, 66);
        chk("plot_count", plots, 64);
        chk("done_select", dsel, v.eg ? 2 : 1);
        chk("draw_flash", flash_draw, 0);
        if (dsel[1]) req1 = 1'b0;
        if (dsel[0]) req0 = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("idle_after", {busy, done0, done1, plot}, 4'b0000);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("reset_outputs",
            {done0, done1, busy, dp_load, dp_enable, dp_flash, plot, dp_x, dp_y, dp_colour},
            '0);
        resetn = 1'b1;
    endtask

    vec_t tbl [7];
    vec_t v;

    initial begin
        //          r0 x0   y0   c0 f0 r1 x1   y1   c1 f1 late eg ex   ey   ec f
        tbl[0] = {1'b1, 8'd10,  7'd20,  3'd4, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 1'b0, 1'b0, 8'd10,  8'd20,  3'd4, 1'b0};
        tbl[1] = {1'b1, 8'd33,  7'd5,   3'd1, 1'b0, 1'b1, 8'd200, 7'd100, 3'd2, 1'b1, 1'b0, 1'b1, 8'd200, 8'd100, 3'd2, 1'b1};
        tbl[2] = {1'b1, 8'd33,  7'd5,   3'd1, 1'b0, 1'b1, 8'd7,   7'd9,   3'd6, 1'b0, 1'b0, 1'b0, 8'd33,  8'd5,   3'd1, 1'b0};
        tbl[3] = {1'b1, 8'd33,  7'd5,   3'd1, 1'b0, 1'b1, 8'd7,   7'd9,   3'd6, 1'b0, 1'b0, 1'b1, 8'd7,   8'd9,   3'd6, 1'b0};
        tbl[4] = {1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 1'b1, 8'd255, 7'd127, 3'd3, 1'b1, 1'b0, 1'b1, 8'd255, 8'd127, 3'd3, 1'b1};
        tbl[5] = {1'b1, 8'd250, 7'd0,   3'd7, 1'b1, 1'b1, 8'd4,   7'd4,   3'd5, 1'b0, 1'b1, 1'b0, 8'd250, 8'd0,   3'd7, 1'b1};
        tbl[6] = {1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 1'b1, 8'd4,   7'd4,   3'd5, 1'b0, 1'b0, 1'b1, 8'd4,   8'd4,   3'd5, 1'b0};

        resetn = 1'b0;
        req0 = 1'b0; x0 = '0; y0 = '0; colour0 = '0; flash0 = 1'b0;
        req1 = 1'b0; x1 = '0; y1 = '0; colour1 = '0; flash1 = 1'b0;
        @(negedge clock);
        do_reset();

        // Tie straight after reset goes to requester 0, then held req1 follows.
        v = {1'b1, 8'd10, 7'd20, 3'd4, 1'b0, 1'b1, 8'd90, 7'd60, 3'd2, 1'b0, 1'b0, 1'b0, 8'd10, 8'd20, 3'd4, 1'b0};
        run_cmd(v);
        v = {1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1, 8'd90, 7'd60, 3'd2, 1'b0, 1'b0, 1'b1, 8'd90, 8'd60, 3'd2, 1'b0};
        run_cmd(v);

        for (int i = 0; i < 7; i++) run_cmd(tbl[i]);

        // Abort in the middle of DRAW: no done, then a full redraw.
        req0 = 1'b1; x0 = 8'd12; y0 = 7'd34; colour0 = 3'd5; flash0 = 1'b0;
        @(posedge clock); @(negedge clock);
        for (int k = 0; k < 31; k++) begin
            @(posedge clock); @(negedge clock);
        end
        chk("abort_in_draw", {plot, busy}, 2'b11);
        resetn = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("abort_outputs", {busy, plot, done0, done1, dp_enable, dp_x}, '0);
        resetn = 1'b1;
        v = {1'b1, 8'd12, 7'd34, 3'd5, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd12, 8'd34, 3'd5, 1'b0};
        run_cmd(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
